aes_req_arbiter: RTL
====================

// Module: aes_req_arbiter
// PURPOSE
//  Shares one AES-128 encryption core (start/done handshake, 128b data/key/out) between NUM_REQ
//  requesters. Round-robin arbitration, launches core, waits for done, returns ciphertext with requester id.
//  Sits between client blocks and the single AES instance; only driver of the core's start/data/key.
// PARAMETERS
//  NUM_REQ   4    number of requesters (2..8)
//  ID_W      2    width of rsp_id; must equal clog2(NUM_REQ)
//  TIMEOUT   64   max cycles in WAIT before aborting job with error (>=16)
// PORTS
//  clk        in   1            clock, all logic on rising edge
//  rst        in   1            synchronous reset, active-high
//  req_valid  in   NUM_REQ      per-requester job request
//  req_ready  out  NUM_REQ      one-hot accept strobe; job taken when valid&ready
//  req_data   in   NUM_REQ*128  plaintext, requester i at [128*i+127:128*i]
//  req_key    in   NUM_REQ*128  key, same packing
//  rsp_valid  out  1            result available
//  rsp_ready  in   1            consumer accepts result
//  rsp_data   out  128          ciphertext (0 on error)
//  rsp_id     out  ID_W         index of requester owning result
//  rsp_err    out  1            1 = job aborted by timeout
//  aes_start  out  1            one-cycle start pulse to core
//  aes_data   out  128          plaintext to core, stable from start until done
//  aes_key    out  128          key to core, stable from start until done
//  aes_done   in   1            core completion strobe
//  aes_out    in   128          core ciphertext, valid when aes_done=1
// BEHAVIOUR
//  Reset: state=IDLE; req_ready=0, rsp_valid=0, rsp_data=0, rsp_id=0, rsp_err=0, aes_start=0,
//   aes_data=0, aes_key=0, wait counter=0, last_grant=NUM_REQ-1 (req 0 highest priority first).
//  FSM: IDLE -> LAUNCH -> WAIT -> RESP -> IDLE.
//  IDLE: if any req_valid, grant g = first valid index scanning last_grant+1, +2, ... mod NUM_REQ;
//   req_ready[g]=1 combinationally this cycle only; latch req_data/key[g] into aes_data/aes_key,
//   g into rsp_id; -> LAUNCH. No valid: stay, req_ready=0.
//  LAUNCH: aes_start=1 for exactly this cycle; counter cleared; -> WAIT.
//  WAIT: aes_done=1 -> rsp_data<=aes_out, rsp_err<=0, -> RESP. Else counter==TIMEOUT-1 ->
//   rsp_data<=0, rsp_err<=1, -> RESP. Else counter+1.
//  RESP: rsp_valid=1, rsp_data/id/err held stable until rsp_valid&rsp_ready; on handshake
//   last_grant<=rsp_id, -> IDLE. rsp_valid registered; never depends on rsp_ready combinationally.
//  Latency: accept at cycle T, aes_start at T+1, done at D>=T+2, rsp_valid at D+1;
//   next accept earliest cycle after response handshake. Throughput one job in flight.
//  req_ready is all-zero outside IDLE; req_valid while busy is held pending, not dropped.
//  Requester may deassert req_valid before grant (no penalty); data/key sampled only at accept.
//  aes_done outside WAIT is ignored (incl. done in LAUNCH cycle); aes_out sampled only with done in WAIT.
//  Done and timeout in same WAIT cycle: done wins, rsp_err=0.
//  Continuous rsp_ready=1: RESP lasts one cycle.
//  rst mid-operation: all state/outputs return to reset values next edge; job lost, no rsp.
// TESTING (bench uses core model: done 10 cycles after start, out = data ^ key)
//  Single req: req1 data=128'h0123..cdef key=128'hFFFF..FFFF -> one aes_start, rsp_valid 12 cycles
//   after accept, rsp_data=128'hFEDC..3210, rsp_id=1, rsp_err=0.
//  All 4 valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0,...; each rsp_id matches its data^key.
//  Req0 and req2 valid, last_grant=0 -> req2 granted first, then req0; req1 never granted.
//  Backpressure: rsp_ready=0 for 20 cycles -> rsp_valid/data/id stable, req_ready stays 0, then one handshake.
//  Timeout: core model never asserts done -> rsp_valid at cycle TIMEOUT+2 after accept, rsp_err=1,
//   rsp_data=0; stray aes_done in IDLE afterwards produces no response.
//  Reset in WAIT: rst=1 one cycle -> all outputs 0 next cycle; subsequent req0 served normally with id 0.

Source files
------------

// File: rtl/aes_req_arbiter_if.sv
// Bundle of requester, response and AES-core signals around aes_req_arbiter.
// slave = the arbiter's view; master = clients plus core as seen from outside.
interface aes_req_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
);
   logic [NUM_REQ-1:0]     req_valid;
   logic [NUM_REQ-1:0]     req_ready;
   logic [NUM_REQ*128-1:0] req_data;
   logic [NUM_REQ*128-1:0] req_key;
   logic                   rsp_valid;
   logic                   rsp_ready;
   logic [127:0]           rsp_data;
   logic [ID_W-1:0]        rsp_id;
   logic                   rsp_err;
   logic                   aes_start;
   logic [127:0]           aes_data;
   logic [127:0]           aes_key;
   logic                   aes_done;
   logic [127:0]           aes_out;

   modport master (
      output req_valid, req_data, req_key, rsp_ready, aes_done, aes_out,
      input  req_ready, rsp_valid, rsp_data, rsp_id, rsp_err, aes_start, aes_data, aes_key
   );

   modport slave (
      input  req_valid, req_data, req_key, rsp_ready, aes_done, aes_out,
      output req_ready, rsp_valid, rsp_data, rsp_id, rsp_err, aes_start, aes_data, aes_key
   );
endinterface

// File: rtl/aes_req_arbiter.sv
// Round-robin sharing of one AES-128 core among NUM_REQ requesters; one job in flight,
// with a WAIT-state watchdog that turns a silent core into an error response.
module aes_req_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2,
   parameter int TIMEOUT = 64
) (
   input logic          clk,
   input logic          rst,
   aes_req_arbiter_if.slave bus
);
   localparam int CNT_W = $clog2(TIMEOUT);

   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

   state_t             state_reg;
   logic [ID_W-1:0]    last_grant_reg;
   logic [ID_W-1:0]    rsp_id_reg;
   logic [CNT_W-1:0]   cnt_reg;
   logic               rsp_valid_reg;
   logic               rsp_err_reg;
   logic               aes_start_reg;
   logic [127:0]       rsp_data_reg;
   logic [127:0]       aes_data_reg;
   logic [127:0]       aes_key_reg;

   logic [127:0]       data_arr [NUM_REQ];
   logic [127:0]       key_arr  [NUM_REQ];
   logic [NUM_REQ-1:0] grant_onehot;
   logic [ID_W-1:0]    grant_idx;
   logic [ID_W-1:0]    cand_idx;
   logic               grant_any;

   function automatic int wrap_idx(input int v);
      return (v >= NUM_REQ) ? v - NUM_REQ : v;
   endfunction

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign data_arr[gi]     = bus.req_data[128*gi +: 128];
         assign key_arr[gi]      = bus.req_key[128*gi +: 128];
         assign grant_onehot[gi] = (grant_idx == ID_W'(gi));
      end
   endgenerate

   // Scan farthest-to-nearest from last_grant so the nearest valid requester overwrites.
   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      cand_idx  = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         cand_idx = ID_W'(wrap_idx(int'(last_grant_reg) + k));
         if (bus.req_valid[cand_idx]) begin
            grant_any = 1'b1;
            grant_idx = cand_idx;
         end
      end
   end

   assign bus.req_ready = (state_reg == IDLE && grant_any) ? grant_onehot : '0;
   assign bus.rsp_valid = rsp_valid_reg;
   assign bus.rsp_data  = rsp_data_reg;
   assign bus.rsp_id    = rsp_id_reg;
   assign bus.rsp_err   = rsp_err_reg;
   assign bus.aes_start = aes_start_reg;
   assign bus.aes_data  = aes_data_reg;
   assign bus.aes_key   = aes_key_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         last_grant_reg <= ID_W'(NUM_REQ - 1);
         rsp_id_reg     <= '0;
         cnt_reg        <= '0;
         rsp_valid_reg  <= 1'b0;
         rsp_err_reg    <= 1'b0;
         aes_start_reg  <= 1'b0;
         rsp_data_reg   <= '0;
         aes_data_reg   <= '0;
         aes_key_reg    <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (grant_any) begin
                  aes_data_reg  <= data_arr[grant_idx];
                  aes_key_reg   <= key_arr[grant_idx];
                  rsp_id_reg    <= grant_idx;
                  aes_start_reg <= 1'b1;
                  state_reg     <= LAUNCH;
               end
            end
            LAUNCH: begin
               aes_start_reg <= 1'b0;
               cnt_reg       <= '0;
               state_reg     <= WAIT;
            end
            WAIT: begin
               // A done arriving on the watchdog's last cycle still delivers real data.
               if (bus.aes_done) begin
                  rsp_data_reg  <= bus.aes_out;
                  rsp_err_reg   <= 1'b0;
                  rsp_valid_reg <= 1'b1;
                  state_reg     <= RESP;
               end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
                  rsp_data_reg  <= '0;
                  rsp_err_reg   <= 1'b1;
                  rsp_valid_reg <= 1'b1;
                  state_reg     <= RESP;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_reg  <= 1'b0;
                  last_grant_reg <= rsp_id_reg;
                  state_reg      <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end
endmodule
